// File: rtl/occupancy_mode_controller.sv
// Occupancy supervisor: person counter, ARMED/OCCUPIED/LEAVING FSM and registered AC/eco/security enables.
// Optional LEAVING grace timer is built only when OCCUPANCY_LEAVE_GRACE_EN is defined.
module occupancy_mode_controller #(
  parameter int PCNT_W      = 8,
  parameter int GRACE_TICKS = 30
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              entry_pulse_i,
  input  logic              exit_pulse_i,
  input  logic              tick_i,
  input  logic [1:0]        user_ac_mode_i,
  input  logic              user_mode_load_i,
  input  logic              eco_enable_i,
  input  logic              err_clr_i,
  output logic [PCNT_W-1:0] person_count_o,
  output logic [1:0]        ac_working_mode_o,
  output logic              eco_mode_valid_o,
  output logic              security_control_valid_o,
  output logic [1:0]        state_o,
  output logic              count_err_o
);

  typedef enum logic [1:0] {
    ST_ARMED    = 2'b00,
    ST_OCCUPIED = 2'b01,
    ST_LEAVING  = 2'b10,
    ST_ILLEGAL  = 2'b11
  } state_t;

  localparam logic [PCNT_W-1:0] CNT_MAX = {PCNT_W{1'b1}};

  state_t            state_q, state_d;
  logic [PCNT_W-1:0] count_q, count_d;
  logic              err_q, err_d;
  logic [1:0]        mode_q, mode_d;
  logic [1:0]        ac_mode_q, ac_mode_d;
  logic              eco_q, eco_d;
  logic              sec_q, sec_d;
  logic              err_set;

`ifdef OCCUPANCY_LEAVE_GRACE_EN
  localparam logic [7:0] GRACE_LAST = 8'(GRACE_TICKS - 1);
  logic [7:0] timer_q, timer_d;
`else
  localparam logic [7:0] GRACE_UNUSED = 8'(GRACE_TICKS);
  logic unused_grace;
  assign unused_grace = ^{tick_i, GRACE_UNUSED};
`endif

  // Counter with saturation; a fresh error takes priority over a clear
  always_comb begin
    count_d = count_q;
    err_set = 1'b0;
    if (entry_pulse_i && !exit_pulse_i) begin
      if (count_q == CNT_MAX) err_set = 1'b1;
      else                    count_d = count_q + 1'b1;
    end else if (exit_pulse_i && !entry_pulse_i) begin
      if (count_q == '0) err_set = 1'b1;
      else               count_d = count_q - 1'b1;
    end
    if (err_set)        err_d = 1'b1;
    else if (err_clr_i) err_d = 1'b0;
    else                err_d = err_q;
    mode_d = user_mode_load_i ? user_ac_mode_i : mode_q;
  end

  always_comb begin
    state_d = state_q;
`ifdef OCCUPANCY_LEAVE_GRACE_EN
    timer_d = timer_q;
`endif
    case (state_q)
      ST_ARMED: begin
        if (count_d != '0) state_d = ST_OCCUPIED;
      end
      ST_OCCUPIED: begin
        if (count_d == '0) begin
`ifdef OCCUPANCY_LEAVE_GRACE_EN
          state_d = ST_LEAVING;
          timer_d = 8'd0;
`else
          state_d = ST_ARMED;
`endif
        end
      end
`ifdef OCCUPANCY_LEAVE_GRACE_EN
      ST_LEAVING: begin
        if (count_d != '0) begin
          state_d = ST_OCCUPIED;
        end else if (tick_i) begin
          if (timer_q == GRACE_LAST) begin
            state_d = ST_ARMED;
            timer_d = 8'd0;
          end else begin
            timer_d = timer_q + 8'd1;
          end
        end
      end
`endif
      default: state_d = ST_ARMED;
    endcase

    // Outputs are registered from the next state so they change together with state_o
    if (state_d == ST_ARMED) begin
      ac_mode_d = 2'b00;
      eco_d     = 1'b1;
      sec_d     = 1'b1;
    end else begin
      ac_mode_d = mode_d;
      eco_d     = eco_enable_i;
      sec_d     = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_ARMED;
      count_q   <= '0;
      err_q     <= 1'b0;
      mode_q    <= 2'b00;
      ac_mode_q <= 2'b00;
      eco_q     <= 1'b1;
      sec_q     <= 1'b1;
`ifdef OCCUPANCY_LEAVE_GRACE_EN
      timer_q   <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      err_q     <= err_d;
      mode_q    <= mode_d;
      ac_mode_q <= ac_mode_d;
      eco_q     <= eco_d;
      sec_q     <= sec_d;
`ifdef OCCUPANCY_LEAVE_GRACE_EN
      timer_q   <= timer_d;
`endif
    end
  end

  assign person_count_o           = count_q;
  assign ac_working_mode_o        = ac_mode_q;
  assign eco_mode_valid_o         = eco_q;
  assign security_control_valid_o = sec_q;
  assign state_o                  = state_q;
  assign count_err_o              = err_q;

endmodule

// File: tb/tb_occupancy_mode_controller.sv
// Directed bench for occupancy_mode_controller: vector table plus hand sequences for grace/reset/saturation.
module tb_occupancy_mode_controller;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       entry_pulse_i = 1'b0;
  logic       exit_pulse_i = 1'b0;
  logic       tick_i = 1'b0;
  logic [1:0] user_ac_mode_i = 2'b00;
  logic       user_mode_load_i = 1'b0;
  logic       eco_enable_i = 1'b0;
  logic       err_clr_i = 1'b0;
  logic [7:0] person_count_o;
  logic [1:0] ac_working_mode_o;
  logic       eco_mode_valid_o;
  logic       security_control_valid_o;
  logic [1:0] state_o;
  logic       count_err_o;

  int checks = 0;
  int errors = 0;

  occupancy_mode_controller #(.PCNT_W(8), .GRACE_TICKS(3)) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .entry_pulse_i(entry_pulse_i),
    .exit_pulse_i(exit_pulse_i),
    .tick_i(tick_i),
    .user_ac_mode_i(user_ac_mode_i),
    .user_mode_load_i(user_mode_load_i),
    .eco_enable_i(eco_enable_i),
    .err_clr_i(err_clr_i),
    .person_count_o(person_count_o),
    .ac_working_mode_o(ac_working_mode_o),
    .eco_mode_valid_o(eco_mode_valid_o),
    .security_control_valid_o(security_control_valid_o),
    .state_o(state_o),
    .count_err_o(count_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       entry;
    logic       exitp;
    logic       tick;
    logic       load;
    logic [1:0] mode;
    logic       eco;
    logic       clr;
    int         e_cnt;
    int         e_st;
    int         e_ac;
    int         e_eco;
    int         e_sec;
    int         e_err;
  } vec_t;

  vec_t vecs [7];

  task automatic checkField(input string tag, input string field, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s.%s: got %0d expected %0d", tag, field, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input int e_cnt, input int e_st, input int e_ac,
                             input int e_eco, input int e_sec, input int e_err);
    checkField(tag, "count", int'(person_count_o), e_cnt);
    checkField(tag, "state", int'(state_o), e_st);
    checkField(tag, "ac_mode", int'(ac_working_mode_o), e_ac);
    checkField(tag, "eco", int'(eco_mode_valid_o), e_eco);
    checkField(tag, "security", int'(security_control_valid_o), e_sec);
    checkField(tag, "err", int'(count_err_o), e_err);
  endtask

  // One clock cycle of stimulus; pulses are dropped after the edge, levels are kept
  task automatic applyStimulus(input logic entry, input logic exitp, input logic tick, input logic load,
                               input logic [1:0] mode, input logic eco, input logic clr);
    entry_pulse_i    = entry;
    exit_pulse_i     = exitp;
    tick_i           = tick;
    user_mode_load_i = load;
    user_ac_mode_i   = mode;
    eco_enable_i     = eco;
    err_clr_i        = clr;
    @(posedge clk_i);
    #1;
    entry_pulse_i    = 1'b0;
    exit_pulse_i     = 1'b0;
    tick_i           = 1'b0;
    user_mode_load_i = 1'b0;
    err_clr_i        = 1'b0;
  endtask

  task automatic doReset();
    @(posedge clk_i);
    #2;
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 0, 0, 0, 1, 1, 0};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 0, 0, 0, 1, 1, 0};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1, 1, 1, 1, 0, 0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 1, 1, 1, 1, 0, 0};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 2, 1, 1, 0, 0, 0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 2, 1, 2, 0, 0, 0};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1, 1, 2, 0, 0, 0};

    repeat (3) @(posedge clk_i);
    #1;
    checkOutput("reset_hold", 0, 0, 0, 1, 1, 0);
    rst_i = 1'b0;
    #2;
    checkOutput("reset_release", 0, 0, 0, 1, 1, 0);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].entry, vecs[i].exitp, vecs[i].tick, vecs[i].load,
                    vecs[i].mode, vecs[i].eco, vecs[i].clr);
      checkOutput($sformatf("vec%0d", i), vecs[i].e_cnt, vecs[i].e_st, vecs[i].e_ac,
                  vecs[i].e_eco, vecs[i].e_sec, vecs[i].e_err);
    end

`ifdef OCCUPANCY_LEAVE_GRACE_EN
    // Tick in the entering cycle is not counted, so three more ticks are needed
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0);
    checkOutput("grace_enter", 0, 2, 2, 0, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0);
    checkOutput("grace_idle", 0, 2, 2, 0, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0);
    checkOutput("grace_tick1", 0, 2, 2, 0, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0);
    checkOutput("grace_tick2", 0, 2, 2, 0, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0);
    checkOutput("grace_tick3", 0, 0, 0, 1, 1, 0);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0);
    checkOutput("rearm_entry", 1, 1, 2, 0, 0, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0);
    checkOutput("leave2", 0, 2, 2, 0, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0);
    checkOutput("leave2_tick2", 0, 2, 2, 0, 0, 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0);
    checkOutput("entry_beats_expiry", 1, 1, 2, 0, 0, 0);

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0);
    checkOutput("leave3_tick2", 0, 2, 2, 0, 0, 0);
    rst_i = 1'b1;
    #2;
    checkOutput("reset_mid_leaving", 0, 0, 0, 1, 1, 0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0);
    checkOutput("after_reset_tick", 0, 0, 0, 1, 1, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0);
    checkOutput("after_reset_mode_cleared", 1, 1, 0, 0, 0, 0);
`else
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0);
    checkOutput("direct_arm", 0, 0, 0, 1, 1, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0);
    checkOutput("tick_ignored", 0, 0, 0, 1, 1, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0);
    checkOutput("two_entries", 2, 1, 2, 0, 0, 0);
    rst_i = 1'b1;
    #2;
    checkOutput("reset_mid_count", 0, 0, 0, 1, 1, 0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0);
    checkOutput("after_reset_mode_cleared", 1, 1, 0, 0, 0, 0);
`endif

    doReset();
    checkOutput("err_start", 0, 0, 0, 1, 1, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    checkOutput("underflow", 0, 0, 0, 1, 1, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
    checkOutput("err_clear", 0, 0, 0, 1, 1, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
    checkOutput("err_set_beats_clear", 0, 0, 0, 1, 1, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
    checkOutput("err_clear2", 0, 0, 0, 1, 1, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0);
    checkOutput("load_in_armed", 0, 0, 0, 1, 1, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0);
    checkOutput("stored_mode_appears", 1, 1, 3, 0, 0, 0);
    for (int i = 0; i < 254; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0);
    end
    checkOutput("count_255", 255, 1, 3, 0, 0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0);
    checkOutput("overflow_saturate", 255, 1, 3, 0, 0, 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 1'b0, 1'b0);
    checkOutput("err_sticky", 254, 1, 3, 0, 0, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 1'b1, 1'b1);
    checkOutput("err_clear3", 254, 1, 3, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
